// File: rtl/mips_defs.sv
// Shared MIPS opcode, field and hazard-timing definitions.
// Used by the per-stage decoders and the hazard/pipeline register block.
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BB      = 6'h3F;
    localparam logic [5:0] FN_JR      = 6'h08;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       use_rs;
        logic       use_rt;
        tuse_t      tuse_rs;
        tuse_t      tuse_rt;
        tnew_t      tnew_e;
        tnew_t      tnew_m;
    } iclass_t;

    // Producer in a later stage blocks the consumer in D when it writes
    // a read operand later than the consumer needs it.
    function automatic logic raw_hazard(
        input iclass_t    d,
        input logic [4:0] dst,
        input tnew_t      tnew
    );
        logic rs_hit;
        logic rt_hit;
        rs_hit = d.use_rs && (d.rs == dst) && (tnew > d.tuse_rs);
        rt_hit = d.use_rt && (d.rt == dst) && (tnew > d.tuse_rt);
        return (dst != REG_ZERO) && (rs_hit || rt_hit);
    endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational decode of one instruction word into operand use,
// destination register and Tuse/Tnew timing.
import mips_defs::*;

module instr_class (
    input  logic [31:0] ir,
    output iclass_t     cls
);

    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op   = ir[OP_HI:OP_LO];
    assign func = ir[FN_HI:FN_LO];
    assign rs   = ir[RS_HI:RS_LO];
    assign rt   = ir[RT_HI:RT_LO];
    assign rd   = ir[RD_HI:RD_LO];
    assign unused_shamt = ^ir[10:6];

    logic cal_r;
    logic cal_i;
    logic ld;
    logic st;
    logic beq;
    logic jal;
    logic jr;
    logic bb;

    assign cal_r = (op == OP_SPECIAL) && (func != 6'h00) && (func != FN_JR);
    assign jr    = (op == OP_SPECIAL) && (func == FN_JR);
    assign cal_i = (op == OP_ORI) || (op == OP_LUI);
    assign ld    = (op == OP_LW);
    assign st    = (op == OP_SW);
    assign beq   = (op == OP_BEQ);
    assign jal   = (op == OP_JAL);
    assign bb    = (op == OP_BB);

    always_comb begin
        cls    = '0;
        cls.rs = rs;
        cls.rt = rt;
        unique case (1'b1)
            cal_r: begin
                cls.dst     = rd;
                cls.use_rs  = 1'b1;
                cls.use_rt  = 1'b1;
                cls.tuse_rs = T1;
                cls.tuse_rt = T1;
                cls.tnew_e  = T1;
            end
            cal_i: begin
                cls.dst     = rt;
                cls.use_rs  = 1'b1;
                cls.tuse_rs = T1;
                cls.tnew_e  = T1;
            end
            ld: begin
                cls.dst     = rt;
                cls.use_rs  = 1'b1;
                cls.tuse_rs = T1;
                cls.tnew_e  = T2;
                cls.tnew_m  = T1;
            end
            st: begin
                cls.use_rs  = 1'b1;
                cls.use_rt  = 1'b1;
                cls.tuse_rs = T1;
                cls.tuse_rt = T2;
            end
            beq, bb: begin
                cls.use_rs  = 1'b1;
                cls.use_rt  = 1'b1;
                cls.tuse_rs = T0;
                cls.tuse_rt = T0;
            end
            jal: begin
                cls.dst = REG_RA;
            end
            jr: begin
                cls.use_rs  = 1'b1;
                cls.tuse_rs = T0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_regs.sv
// D/E/M/W instruction and PC+8 registers with Tuse/Tnew stall
// detection and a saturating stall-cycle counter.
import mips_defs::*;

module pipe_hazard_regs #(
    parameter int DW  = 32,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [DW-1:0]  instr_f,
    input  logic [DW-1:0]  pc_f,
    output logic [DW-1:0]  ir_d,
    output logic [DW-1:0]  ir_e,
    output logic [DW-1:0]  ir_m,
    output logic [DW-1:0]  ir_w,
    output logic [DW-1:0]  pc8_e,
    output logic [DW-1:0]  pc8_m,
    output logic [DW-1:0]  pc8_w,
    output logic           stall,
    output logic [SCW-1:0] stall_cnt
);

    logic [DW-1:0] pc8_d;
    iclass_t       cls_d;
    iclass_t       cls_e;
    iclass_t       cls_m;
    logic          unused_cls;

    instr_class u_cls_d (
        .ir  (ir_d[31:0]),
        .cls (cls_d)
    );

    instr_class u_cls_e (
        .ir  (ir_e[31:0]),
        .cls (cls_e)
    );

    instr_class u_cls_m (
        .ir  (ir_m[31:0]),
        .cls (cls_m)
    );

    // W never stalls anyone: every W result is already available.
    assign stall = raw_hazard(cls_d, cls_e.dst, cls_e.tnew_e)
                || raw_hazard(cls_d, cls_m.dst, cls_m.tnew_m);

    assign unused_cls = ^{cls_d.dst, cls_d.tnew_e, cls_d.tnew_m,
                          cls_e.rs, cls_e.rt, cls_e.use_rs, cls_e.use_rt,
                          cls_e.tuse_rs, cls_e.tuse_rt, cls_e.tnew_m,
                          cls_m.rs, cls_m.rt, cls_m.use_rs, cls_m.use_rt,
                          cls_m.tuse_rs, cls_m.tuse_rt, cls_m.tnew_e};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_d  <= '0;
            ir_e  <= '0;
            ir_m  <= '0;
            ir_w  <= '0;
            pc8_d <= '0;
            pc8_e <= '0;
            pc8_m <= '0;
            pc8_w <= '0;
        end else begin
            if (stall) begin
                ir_e  <= '0;
                pc8_e <= '0;
            end else begin
                ir_d  <= instr_f;
                pc8_d <= pc_f + DW'(8);
                ir_e  <= ir_d;
                pc8_e <= pc8_d;
            end
            ir_m  <= ir_e;
            pc8_m <= pc8_e;
            ir_w  <= ir_m;
            pc8_w <= pc8_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {SCW{1'b1}})) begin
            stall_cnt <= stall_cnt + SCW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_regs.sv
// Directed vector bench for pipe_hazard_regs: stall timing, bubbles,
// PC+8 transport, reset during a stall and counter saturation.
module tb_pipe_hazard_regs;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] LW1    = 32'h8C01_0000;
    localparam logic [31:0] ADDU2  = 32'h0023_1021;
    localparam logic [31:0] BEQ12  = 32'h1022_0000;
    localparam logic [31:0] ORI1   = 32'h3401_0005;
    localparam logic [31:0] BEQ10  = 32'h1020_0000;
    localparam logic [31:0] ADDU4  = 32'h0021_2021;
    localparam logic [31:0] JAL    = 32'h0C00_0040;
    localparam logic [31:0] JR31   = 32'h03E0_0008;
    localparam logic [31:0] LW5    = 32'h8C05_0000;
    localparam logic [31:0] SW5    = 32'hACC5_0000;
    localparam logic [31:0] ADDU0  = 32'h0022_0021;
    localparam logic [31:0] BEQ00  = 32'h1000_0000;
    localparam logic [31:0] LUI1   = 32'h3C01_0001;
    localparam logic [31:0] LWC    = 32'h8C21_0000;
    localparam logic [31:0] NP     = 32'hFFFF_FFF8;

    logic        clk;
    logic        reset;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] ir_d, ir_e, ir_m, ir_w;
    logic [31:0] pc8_e, pc8_m, pc8_w;
    logic        stall;
    logic [15:0] stall_cnt;

    logic [31:0] unused_ir_d, unused_ir_e, unused_ir_m, unused_ir_w;
    logic [31:0] unused_pc8_e, unused_pc8_m, unused_pc8_w;
    logic        unused_stall;
    logic [3:0]  small_cnt;

    int tests;
    int fails;

    pipe_hazard_regs #(.DW(32), .SCW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr_f   (instr_f),
        .pc_f      (pc_f),
        .ir_d      (ir_d),
        .ir_e      (ir_e),
        .ir_m      (ir_m),
        .ir_w      (ir_w),
        .pc8_e     (pc8_e),
        .pc8_m     (pc8_m),
        .pc8_w     (pc8_w),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    pipe_hazard_regs #(.DW(32), .SCW(4)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .instr_f   (instr_f),
        .pc_f      (pc_f),
        .ir_d      (unused_ir_d),
        .ir_e      (unused_ir_e),
        .ir_m      (unused_ir_m),
        .ir_w      (unused_ir_w),
        .pc8_e     (unused_pc8_e),
        .pc8_m     (unused_pc8_m),
        .pc8_w     (unused_pc8_w),
        .stall     (unused_stall),
        .stall_cnt (small_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] m;
        logic [31:0] pc8e;
        logic        stall;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic [31:0] instr, input logic [31:0] pc,
        input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
        input logic [31:0] pc8e, input logic st, input logic [15:0] cnt
    );
        vec_t v;
        v.instr = instr; v.pc = pc; v.d = d; v.e = e; v.m = m;
        v.pc8e = pc8e; v.stall = st; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ir_d"}, ir_d, 0);
        chk({tag, " ir_e"}, ir_e, 0);
        chk({tag, " ir_m"}, ir_m, 0);
        chk({tag, " ir_w"}, ir_w, 0);
        chk({tag, " pc8_e"}, pc8_e, 0);
        chk({tag, " pc8_m"}, pc8_m, 0);
        chk({tag, " pc8_w"}, pc8_w, 0);
        chk({tag, " stall"}, stall, 0);
        chk({tag, " stall_cnt"}, stall_cnt, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        instr_f = NOP;
        pc_f = 32'h0;

        //  instr  pc           d      e      m      pc8e         st    cnt
        add(LW1,   32'h0,       LW1,   NOP,   NOP,   32'h0,       1'b0, 16'd0);
        add(ADDU2, 32'h4,       ADDU2, LW1,   NOP,   32'h8,       1'b1, 16'd0);
        add(NOP,   NP,          ADDU2, NOP,   LW1,   32'h0,       1'b0, 16'd1);
        add(NOP,   NP,          NOP,   ADDU2, NOP,   32'hC,       1'b0, 16'd1);
        add(NOP,   NP,          NOP,   NOP,   ADDU2, 32'h0,       1'b0, 16'd1);
        add(NOP,   NP,          NOP,   NOP,   NOP,   32'h0,       1'b0, 16'd1);
        add(LW1,   32'h100,     LW1,   NOP,   NOP,   32'h0,       1'b0, 16'd1);
        add(BEQ12, 32'h104,     BEQ12, LW1,   NOP,   32'h108,     1'b1, 16'd1);
        add(NOP,   NP,          BEQ12, NOP,   LW1,   32'h0,       1'b1, 16'd2);
        add(NOP,   NP,          BEQ12, NOP,   NOP,   32'h0,       1'b0, 16'd3);
        add(NOP,   NP,          NOP,   BEQ12, NOP,   32'h10C,     1'b0, 16'd3);
        add(NOP,   NP,          NOP,   NOP,   BEQ12, 32'h0,       1'b0, 16'd3);
        add(ORI1,  32'h200,     ORI1,  NOP,   NOP,   32'h0,       1'b0, 16'd3);
        add(BEQ10, 32'h204,     BEQ10, ORI1,  NOP,   32'h208,     1'b1, 16'd3);
        add(NOP,   NP,          BEQ10, NOP,   ORI1,  32'h0,       1'b0, 16'd4);
        add(NOP,   NP,          NOP,   BEQ10, NOP,   32'h20C,     1'b0, 16'd4);
        add(ORI1,  32'h300,     ORI1,  NOP,   BEQ10, 32'h0,       1'b0, 16'd4);
        add(ADDU4, 32'h304,     ADDU4, ORI1,  NOP,   32'h308,     1'b0, 16'd4);
        add(NOP,   NP,          NOP,   ADDU4, ORI1,  32'h30C,     1'b0, 16'd4);
        add(JAL,   32'h3000,    JAL,   NOP,   ADDU4, 32'h0,       1'b0, 16'd4);
        add(JR31,  32'h3004,    JR31,  JAL,   NOP,   32'h3008,    1'b0, 16'd4);
        add(NOP,   NP,          NOP,   JR31,  JAL,   32'h300C,    1'b0, 16'd4);
        add(LW5,   32'h400,     LW5,   NOP,   JR31,  32'h0,       1'b0, 16'd4);
        add(SW5,   32'h404,     SW5,   LW5,   NOP,   32'h408,     1'b0, 16'd4);
        add(NOP,   NP,          NOP,   SW5,   LW5,   32'h40C,     1'b0, 16'd4);
        add(ADDU0, 32'h500,     ADDU0, NOP,   SW5,   32'h0,       1'b0, 16'd4);
        add(BEQ00, 32'h504,     BEQ00, ADDU0, NOP,   32'h508,     1'b0, 16'd4);
        add(NOP,   32'hFFFFFFFC, NOP,  BEQ00, ADDU0, 32'h50C,     1'b0, 16'd4);
        add(NOP,   NP,          NOP,   NOP,   BEQ00, 32'h4,       1'b0, 16'd4);
        add(NOP,   NP,          NOP,   NOP,   NOP,   32'h0,       1'b0, 16'd4);

        // Reset state, with garbage on the fetch inputs.
        instr_f = LW1;
        pc_f = 32'h1234;
        step();
        step();
        chk_all_zero("reset");
        instr_f = NOP;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            instr_f = tbl[i].instr;
            pc_f = tbl[i].pc;
            step();
            chk($sformatf("row%0d ir_d", i), ir_d, tbl[i].d);
            chk($sformatf("row%0d ir_e", i), ir_e, tbl[i].e);
            chk($sformatf("row%0d ir_m", i), ir_m, tbl[i].m);
            chk($sformatf("row%0d pc8_e", i), pc8_e, tbl[i].pc8e);
            chk($sformatf("row%0d stall", i), stall, tbl[i].stall);
            chk($sformatf("row%0d stall_cnt", i), stall_cnt, tbl[i].cnt);
            if (i >= 1) begin
                chk($sformatf("row%0d ir_w", i), ir_w, tbl[i-1].m);
                chk($sformatf("row%0d pc8_m", i), pc8_m, tbl[i-1].pc8e);
            end
            if (i >= 2) begin
                chk($sformatf("row%0d pc8_w", i), pc8_w, tbl[i-2].pc8e);
            end
        end

        // Reset in the second cycle of a lw/beq stall.
        instr_f = LW1;
        pc_f = 32'h700;
        step();
        instr_f = BEQ12;
        pc_f = 32'h704;
        step();
        chk("midstall first stall", stall, 1);
        instr_f = NOP;
        pc_f = NP;
        step();
        chk("midstall second stall", stall, 1);
        chk("midstall ir_m", ir_m, LW1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        instr_f = LUI1;
        pc_f = 32'h600;
        #3;
        reset = 1'b0;
        step();
        chk("post reset ir_d", ir_d, LUI1);
        chk("post reset ir_e", ir_e, 0);
        chk("post reset stall", stall, 0);
        chk("post reset stall_cnt", stall_cnt, 0);
        step();
        chk("post reset pc8_e", pc8_e, 32'h608);

        // Back-to-back lw $1,0($1): one stall every other cycle.
        reset = 1'b1;
        instr_f = LWC;
        pc_f = 32'h0;
        #2;
        reset = 1'b0;
        for (int c = 0; c < 50; c++) step();
        chk("chain stall_cnt", stall_cnt, 24);
        chk("chain small saturated", small_cnt, 4'hF);
        chk("chain stall", stall, 1);
        step();
        chk("chain small hold", small_cnt, 4'hF);
        chk("chain stall_cnt next", stall_cnt, 25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
